// File: rtl/pc_sequencer.sv
// Program counter and next-PC select with boot/run/halt control,
// misaligned-redirect trap and a wrapping fetch counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      PC_PLUS4,
  input  logic             STALL,
  input  logic             BRANCH_TAKEN,
  input  logic [31:0]      BRANCH_TARGET,
  input  logic             JUMP,
  input  logic [31:0]      JUMP_TARGET,
  input  logic             HALT_REQ,
  input  logic             RESUME,
  output logic [31:0]      PC,
  output logic             FETCH_VALID,
  output logic             HALTED,
  output logic             MISALIGN_ERR,
  output logic [31:0]      EPC,
  output logic [CNT_W-1:0] FETCH_COUNT
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      epc_q, epc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fv_q, fv_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;

  logic             redir;
  logic [31:0]      tgt;

  assign redir = JUMP | BRANCH_TAKEN;
  assign tgt   = JUMP ? JUMP_TARGET : BRANCH_TARGET;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (HALT_REQ) begin
          state_d = S_HALT;
        end else if (!STALL) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (redir && (tgt[1:0] != 2'b00)) begin
            pc_d  = TRAP_VECTOR;
            epc_d = pc_q;
            err_d = 1'b1;
          end else if (redir) begin
            pc_d = tgt;
          end else begin
            pc_d = PC_PLUS4;
          end
        end
      end
      S_HALT: begin
        if (RESUME) state_d = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase
    fv_d     = (state_d == S_RUN);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_VECTOR;
      epc_q    <= 32'h0;
      cnt_q    <= '0;
      fv_q     <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      cnt_q    <= cnt_d;
      fv_q     <= fv_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign PC           = pc_q;
  assign FETCH_VALID  = fv_q;
  assign HALTED       = halted_q;
  assign MISALIGN_ERR = err_q;
  assign EPC          = epc_q;
  assign FETCH_COUNT  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected state per cycle is
// queued with the stimulus and checked one edge later.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, br, jmp, hreq, res;
  logic [31:0] bt, jt;
  logic [31:0] pc, pc4, epc, cnt;
  logic        fv, halted, err;
  logic [31:0] pc_s, epc_s;
  logic [3:0]  cnt_s;
  logic        fv_s, halted_s, err_s;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        halted;
    logic        err;
    logic [31:0] epc;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  assign pc4 = pc + 32'd4;

  pc_sequencer dut (
    .CLK(clk), .RST(rst), .PC_PLUS4(pc4), .STALL(stall),
    .BRANCH_TAKEN(br), .BRANCH_TARGET(bt),
    .JUMP(jmp), .JUMP_TARGET(jt),
    .HALT_REQ(hreq), .RESUME(res),
    .PC(pc), .FETCH_VALID(fv), .HALTED(halted),
    .MISALIGN_ERR(err), .EPC(epc), .FETCH_COUNT(cnt)
  );

  logic [31:0] pc4_s;
  assign pc4_s = pc_s + 32'd4;

  pc_sequencer #(.CNT_W(4)) dut_s (
    .CLK(clk), .RST(rst), .PC_PLUS4(pc4_s), .STALL(stall),
    .BRANCH_TAKEN(br), .BRANCH_TARGET(bt),
    .JUMP(jmp), .JUMP_TARGET(jt),
    .HALT_REQ(hreq), .RESUME(res),
    .PC(pc_s), .FETCH_VALID(fv_s), .HALTED(halted_s),
    .MISALIGN_ERR(err_s), .EPC(epc_s), .FETCH_COUNT(cnt_s)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic drv(input logic r, input logic h,
                     input logic rs, input logic st,
                     input logic j, input logic [31:0] jtg,
                     input logic b, input logic [31:0] btg);
    rst = r; hreq = h; res = rs; stall = st;
    jmp = j; jt = jtg; br = b; bt = btg;
  endtask

  task automatic cyc(input string tag, input logic [31:0] epc_v,
                     input logic fv_v, input logic h_v,
                     input logic e_v, input logic [31:0] ep_v,
                     input logic [31:0] c_v);
    exp_t e, x;
    e.pc = epc_v; e.fv = fv_v; e.halted = h_v;
    e.err = e_v; e.epc = ep_v; e.cnt = c_v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, ".pc"},  pc,  x.pc);
    chk({tag, ".fv"},  {31'd0, fv}, {31'd0, x.fv});
    chk({tag, ".hlt"}, {31'd0, halted}, {31'd0, x.halted});
    chk({tag, ".err"}, {31'd0, err}, {31'd0, x.err});
    chk({tag, ".epc"}, epc, x.epc);
    chk({tag, ".cnt"}, cnt, x.cnt);
    chk({tag, ".cnt4"}, {28'd0, cnt_s}, {28'd0, x.cnt[3:0]});
    chk({tag, ".pc4"}, pc_s, x.pc);
  endtask

  task automatic seq(input string tag, input logic [31:0] p,
                     input logic [31:0] ep, input logic [31:0] c);
    drv(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    cyc(tag, p, 1, 0, 0, ep, c);
  endtask

  initial begin
    drv(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    cyc("rst0", 32'h0, 0, 0, 0, 32'h0, 0);
    drv(1, 0, 0, 1, 1, 32'h40, 1, 32'h44);
    cyc("rst1", 32'h0, 0, 0, 0, 32'h0, 0);
    // boot cycle ignores redirects and stalls
    drv(0, 0, 0, 1, 1, 32'h40, 1, 32'h44);
    cyc("boot", 32'h0, 1, 0, 0, 32'h0, 0);
    seq("seq4", 32'h4, 32'h0, 1);
    seq("seq8", 32'h8, 32'h0, 2);
    seq("seqC", 32'hC, 32'h0, 3);
    seq("seq10", 32'h10, 32'h0, 4);

    drv(0, 0, 0, 0, 1, 32'h200, 1, 32'h300);
    cyc("jpri", 32'h200, 1, 0, 0, 32'h0, 5);
    drv(0, 0, 0, 0, 0, 32'h0, 1, 32'h40);
    cyc("br", 32'h40, 1, 0, 0, 32'h0, 6);

    drv(0, 0, 0, 0, 0, 32'h0, 1, 32'h8);
    cyc("br8", 32'h8, 1, 0, 0, 32'h0, 7);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 1, 0, 32'h0, 1, 32'h100);
      cyc("stall", 32'h8, 1, 0, 0, 32'h0, 7);
    end
    drv(0, 0, 0, 0, 0, 32'h0, 1, 32'h100);
    cyc("unstall", 32'h100, 1, 0, 0, 32'h0, 8);

    drv(0, 0, 0, 0, 1, 32'h20, 0, 32'h0);
    cyc("j20", 32'h20, 1, 0, 0, 32'h0, 9);
    drv(0, 0, 0, 0, 1, 32'h102, 0, 32'h0);
    cyc("trap", 32'h80, 1, 0, 1, 32'h20, 10);
    seq("post", 32'h84, 32'h20, 11);
    drv(0, 0, 0, 0, 0, 32'h0, 1, 32'h89);
    cyc("trapb", 32'h80, 1, 0, 1, 32'h84, 12);

    drv(0, 0, 0, 0, 1, 32'h30, 0, 32'h0);
    cyc("j30", 32'h30, 1, 0, 0, 32'h84, 13);
    drv(0, 1, 0, 1, 1, 32'h500, 0, 32'h0);
    cyc("halt", 32'h30, 0, 1, 0, 32'h84, 13);
    for (int i = 0; i < 4; i++) begin
      drv(0, i[0], 0, 1, 1, 32'h500, 1, 32'h600);
      cyc("halted", 32'h30, 0, 1, 0, 32'h84, 13);
    end
    drv(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    cyc("resume", 32'h30, 1, 0, 0, 32'h84, 13);
    seq("res34", 32'h34, 32'h84, 14);
    drv(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    cyc("halt2", 32'h34, 0, 1, 0, 32'h84, 14);
    drv(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
    cyc("hr_both", 32'h34, 1, 0, 0, 32'h84, 14);
    seq("seq38", 32'h38, 32'h84, 15);

    drv(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    cyc("jtop", 32'hFFFF_FFFC, 1, 0, 0, 32'h84, 16);
    seq("wrap", 32'h0, 32'h84, 17);

    drv(0, 0, 0, 0, 1, 32'h44, 0, 32'h0);
    cyc("j44", 32'h44, 1, 0, 0, 32'h84, 18);
    drv(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    cyc("halt3", 32'h44, 0, 1, 0, 32'h84, 18);
    drv(1, 0, 1, 1, 1, 32'h500, 1, 32'h600);
    cyc("rsthalt", 32'h0, 0, 0, 0, 32'h0, 0);
    drv(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    cyc("boot2", 32'h0, 1, 0, 0, 32'h0, 0);
    for (int i = 1; i <= 17; i++) begin
      seq("cntrun", 32'(i * 4), 32'h0, 32'(i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register and next-PC selection stage of the single-cycle CPU.
- Drives PC into the +4 incrementer and takes its sum back as the sequential next address.
- Chooses between sequential, branch, jump and trap redirects, and supports stall and halt/resume.
- Contains a small control FSM, a misalignment trap with saved exception PC, and a retired-fetch counter.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- TRAP_VECTOR, 32'h0000_0080, PC value loaded on a misaligned redirect.
- CNT_W, 32, width of FETCH_COUNT.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- PC_PLUS4  in  32  incrementer result; must equal PC+4 combinationally.
- STALL  in  1  hold PC this cycle.
- BRANCH_TAKEN  in  1  conditional redirect request.
- BRANCH_TARGET  in  32  branch destination.
- JUMP  in  1  unconditional redirect request.
- JUMP_TARGET  in  32  jump destination.
- HALT_REQ  in  1  enter HALT state.
- RESUME  in  1  leave HALT state.
- PC  out  32  current fetch address; feeds the incrementer and instruction memory.
- FETCH_VALID  out  1  PC holds a valid instruction address this cycle.
- HALTED  out  1  high while in HALT.
- MISALIGN_ERR  out  1  one-cycle pulse when a misaligned redirect is trapped.
- EPC  out  32  address of the instruction whose redirect trapped.
- FETCH_COUNT  out  CNT_W  count of PC advances, wrapping.

Behaviour:
- Single clock domain; RST is sampled only on a CLK rising edge (synchronous, active-high).
- While RST=1 at an edge, all of the following load:
  - state=BOOT, PC=RESET_VECTOR;
  - FETCH_VALID=0, HALTED=0, MISALIGN_ERR=0;
  - EPC=0, FETCH_COUNT=0.
- Reset asserted in any state, mid-stall or mid-halt, takes effect at the next edge and overrides every other input.
- FSM states: BOOT, RUN, HALT.
  - BOOT: FETCH_VALID=0. Next edge goes to RUN with PC unchanged (RESET_VECTOR). Redirect and stall inputs are ignored in BOOT.
  - RUN: FETCH_VALID=1. Next-PC priority, highest first:
    1. HALT_REQ: go to HALT, PC held, no count.
    2. STALL: PC held, no count.
    3. JUMP: PC=JUMP_TARGET.
    4. BRANCH_TAKEN: PC=BRANCH_TARGET.
    5. Otherwise: PC=PC_PLUS4.
    - JUMP and BRANCH_TAKEN together: JUMP wins.
    - STALL masks any redirect in the same cycle; the requester must hold its request.
  - HALT: FETCH_VALID=0, HALTED=1, PC held. RESUME returns to RUN at the next edge, PC unchanged. HALT_REQ and RESUME together in HALT: RESUME wins. STALL is ignored in HALT.
- Misalignment trap (RUN only): if the selected redirect target has bits [1:0] != 0, then at that edge:
  - PC=TRAP_VECTOR; EPC=current PC;
  - MISALIGN_ERR=1 for exactly the following cycle, then 0;
  - FETCH_COUNT increments.
- Sequential PC_PLUS4 is not checked for alignment.
- FETCH_COUNT increments by 1 on every RUN edge where PC changes or reloads: sequential, redirect or trap. It wraps from all-ones to 0 with no flag.
- PC arithmetic is modulo 2^32: PC=32'hFFFF_FFFC sequential gives PC=0, with no error.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- Latency: a redirect requested in cycle N is visible on PC in cycle N+1.

Test Plan:
- Reset then run: RST high 2 cycles, then low, PC_PLUS4=PC+4 → PC stays 0x0 and FETCH_VALID=0 for one cycle, then PC=0x0, 0x4, 0x8, 0xC; FETCH_COUNT=3 after 3 advances.
- Redirects: at PC=0x10 assert JUMP (JUMP_TARGET=0x200) and BRANCH_TAKEN (BRANCH_TARGET=0x300) together → next PC=0x200. A later lone branch to 0x40 → next PC=0x40.
- Stall masking: at PC=0x8, STALL=1 for 3 cycles with BRANCH_TAKEN=1 (target 0x100) → PC stays 0x8 and the count is frozen. Release STALL with the branch held → PC=0x100.
- Misaligned jump: at PC=0x20, JUMP_TARGET=0x102 → next PC=0x80, EPC=0x20, MISALIGN_ERR high for exactly 1 cycle.
- Halt/resume: HALT_REQ at PC=0x30 → HALTED=1, FETCH_VALID=0, PC=0x30 for 5 cycles. RESUME → RUN, PC advances to 0x34 on the following edge. HALT_REQ and RESUME asserted together while halted → exits.
- Wrap and reset priority:
  - Force PC=0xFFFF_FFFC → next PC=0x0.
  - FETCH_COUNT preloaded near max via CNT_W=4 → wraps 0xF→0x0.
  - RST during HALT with JUMP high → PC=RESET_VECTOR, state BOOT.
